// File: rtl/tsv_collector_if.sv
// Result-stream interface of the TSV collector: one word per beat with its
// (row, col) position, a last-word flag and a valid/ready handshake.
interface tsv_collector_if #(
  parameter int DW = 42
);
  logic [DW-1:0] out_data;
  logic [3:0]    out_row;
  logic [3:0]    out_col;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;

  // Collector side drives the stream and observes ready.
  modport master (
    output out_data, out_row, out_col, out_valid, out_last,
    input  out_ready
  );

  // Consumer side observes the stream and drives ready.
  modport slave (
    input  out_data, out_row, out_col, out_valid, out_last,
    output out_ready
  );
endinterface

// File: rtl/tsv_collector.sv
// TSV collector: captures a full GRID x GRID frame of controller results into
// a shadow array and streams the active (GRID+1-kx) x (GRID+1-ky) region out
// row-major over a valid/ready interface, one word per accepted beat.
// Optional feature: define TSV_RELU_EN to zero negative words on output.
module tsv_collector #(
  parameter int GRID = 9,
  parameter int DW   = 42
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [GRID-1:0][GRID-1:0][DW-1:0]   tsv_in,
  input  logic                                tsv_valid,
  input  logic [3:0]                          kernelsize_x,
  input  logic [3:0]                          kernelsize_y,
  tsv_collector_if.master                     st,
  output logic                                frame_done,
  output logic                                busy,
  output logic                                overrun
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;

  logic [GRID-1:0][GRID-1:0][DW-1:0] shadow;

  logic [3:0]    row_q, col_q;
  logic [3:0]    last_row_q, last_col_q;
  logic [DW-1:0] data_q;
  logic          valid_q, last_q;

  logic [3:0] nxt_row, nxt_col;
  logic       nxt_last, cur_last;
  logic [3:0] kx_c, ky_c;
  logic       accept;

  // A kernel size of 0 behaves as 1, anything beyond the grid as the grid.
  function automatic logic [3:0] clamp_k(input logic [3:0] k);
    if (k == 4'd0)           return 4'd1;
    else if (k > 4'(GRID))   return 4'(GRID);
    else                     return k;
  endfunction

  // Output word conditioning; optionally clips negative results to zero.
  function automatic logic [DW-1:0] condition(input logic [DW-1:0] w);
`ifdef TSV_RELU_EN
    return w[DW-1] ? '0 : w;
`else
    return w;
`endif
  endfunction

  assign kx_c   = clamp_k(kernelsize_x);
  assign ky_c   = clamp_k(kernelsize_y);
  assign accept = (state == IDLE) && tsv_valid;

  // Next position in row-major order across the active region.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    nxt_row  = row_q;
    nxt_col  = col_q + 4'd1;
    if (col_q == last_col_q) begin
      nxt_col = 4'd0;
      nxt_row = row_q + 4'd1;
    end
    nxt_last = (nxt_row == last_row_q) && (nxt_col == last_col_q);
    cur_last = (row_q == last_row_q) && (col_q == last_col_q);
  end

  // Frame capture; the shadow only changes when a frame is accepted in IDLE.
  // NOTE: the shadow array is pure datapath storage and deliberately has no reset.
  always_ff @(posedge clk) begin
    if (accept) shadow <= tsv_in;
  end

  // Control FSM with registered stream outputs and status flags.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst) begin
      state      <= IDLE;
      row_q      <= '0;
      col_q      <= '0;
      last_row_q <= '0;
      last_col_q <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          frame_done <= 1'b0;
          if (tsv_valid) begin
            last_row_q <= 4'(GRID) - kx_c;
            last_col_q <= 4'(GRID) - ky_c;
            row_q      <= '0;
            col_q      <= '0;
            busy       <= 1'b1;
            state      <= SEND;
          end
        end

        SEND: begin
          if (tsv_valid) overrun <= 1'b1;
          if (!valid_q) begin
            // First cycle of the frame: present word (0,0) from the shadow.
            data_q  <= condition(shadow[row_q][col_q]);
            last_q  <= cur_last;
            valid_q <= 1'b1;
          end else if (st.out_ready) begin
            if (last_q) begin
              valid_q    <= 1'b0;
              last_q     <= 1'b0;
              frame_done <= 1'b1;
              state      <= DONE;
            end else begin
              row_q  <= nxt_row;
              col_q  <= nxt_col;
              data_q <= condition(shadow[nxt_row][nxt_col]);
              last_q <= nxt_last;
            end
          end
        end

        DONE: begin
          if (tsv_valid) overrun <= 1'b1;
          frame_done <= 1'b0;
          busy       <= 1'b0;
          state      <= IDLE;
        end

        default: begin
          state   <= IDLE;
          valid_q <= 1'b0;
          last_q  <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  assign st.out_data  = data_q;
  assign st.out_row   = row_q;
  assign st.out_col   = col_q;
  assign st.out_valid = valid_q;
  assign st.out_last  = last_q;

endmodule

// File: tb/tb_tsv_collector.sv
// Directed bench for tsv_collector: base frame, backpressure, kernel clamping,
// overrun, mid-frame reset, single-word frame and output conditioning.
module tb_tsv_collector;

  localparam int GRID = 9;
  localparam int DW   = 42;

  logic clk = 1'b0;
  logic rst;
  logic [GRID-1:0][GRID-1:0][DW-1:0] tsv_in;
  logic tsv_valid;
  logic [3:0] kernelsize_x, kernelsize_y;
  logic frame_done, busy, overrun;

  logic [DW-1:0] model [GRID][GRID];

  int pass_cnt  = 0;
  int total_cnt = 0;

  tsv_collector_if #(.DW(DW)) st ();

  tsv_collector #(.GRID(GRID), .DW(DW)) dut (
    .clk          (clk),
    .rst          (rst),
    .tsv_in       (tsv_in),
    .tsv_valid    (tsv_valid),
    .kernelsize_x (kernelsize_x),
    .kernelsize_y (kernelsize_y),
    .st           (st),
    .frame_done   (frame_done),
    .busy         (busy),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got running required finished");
    $fatal(1);
  end

  // Frame with word[r][c] = r*16 + c, mirrored into the expected model.
  task automatic load_frame();
    for (int r = 0; r < GRID; r++)
      for (int c = 0; c < GRID; c++) begin
        tsv_in[r][c] = DW'(r * 16 + c);
        model[r][c]  = DW'(r * 16 + c);
      end
  endtask

  // Pulse tsv_valid for one edge, check the one-cycle priming gap, and
  // return at the falling edge where word (0,0) must be visible.
  task automatic send_frame(input string name, input logic [3:0] kx, input logic [3:0] ky);
    @(negedge clk);
    kernelsize_x = kx;
    kernelsize_y = ky;
    tsv_valid    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tsv_valid = 1'b0;
    total_cnt++;
    if (st.out_valid !== 1'b0 || busy !== 1'b1)
      $display("FAIL %s latency: out_valid=%b busy=%b, required out_valid=0 busy=1",
               name, st.out_valid, busy);
    else pass_cnt++;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Walk the stream word by word against the model, optionally stalling with
  // ready pattern 1,0,0 and optionally firing a second frame at word inject_at.
  task automatic consume_frame(input string name, input int lr, input int lc,
                               input bit stall, input int inject_at, output int words);
    int  er, ec, p;
    bit  done_seen, injected, rdy;
    logic [DW+8:0] got, want;
    er = 0; ec = 0; p = 0; words = 0; done_seen = 0; injected = 0;
    for (int cyc = 0; cyc < 2000 && !done_seen; cyc++) begin
      tsv_valid = 1'b0;
      want = {model[er][ec], 4'(er), 4'(ec), 1'((er == lr) && (ec == lc))};
      got  = {st.out_data, st.out_row, st.out_col, st.out_last};
      total_cnt++;
      if (st.out_valid !== 1'b1 || got !== want)
        $display("FAIL %s word %0d: valid=%b {data,row,col,last}=%h, required valid=1 %h",
                 name, words, st.out_valid, got, want);
      else pass_cnt++;
      if (!injected && inject_at == words) begin
        for (int r = 0; r < GRID; r++)
          for (int c = 0; c < GRID; c++)
            tsv_in[r][c] = DW'(12'hA00 + r * 16 + c);
        tsv_valid = 1'b1;
        injected  = 1'b1;
      end
      rdy = stall ? (p % 3 == 0) : 1'b1;
      p++;
      st.out_ready = rdy;
      @(posedge clk);
      @(negedge clk);
      if (rdy) begin
        words++;
        if (er == lr && ec == lc) done_seen = 1'b1;
        else if (ec == lc) begin ec = 0; er++; end
        else ec++;
      end
    end
    tsv_valid = 1'b0;
    total_cnt++;
    if (!done_seen) $display("FAIL %s end: last word not accepted in budget, got %0d words", name, words);
    else pass_cnt++;
    total_cnt++;
    if (frame_done !== 1'b1 || st.out_valid !== 1'b0 || busy !== 1'b1)
      $display("FAIL %s done: frame_done=%b out_valid=%b busy=%b, required 1 0 1",
               name, frame_done, st.out_valid, busy);
    else pass_cnt++;
    @(posedge clk);
    @(negedge clk);
    total_cnt++;
    if (frame_done !== 1'b0 || busy !== 1'b0)
      $display("FAIL %s idle: frame_done=%b busy=%b, required 0 0", name, frame_done, busy);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst = 1'b1; tsv_valid = 1'b0; st.out_ready = 1'b0;
    kernelsize_x = 4'd2; kernelsize_y = 4'd2;
    load_frame();
    #3 rst = 1'b0;
    #1;
    total_cnt++;
    if ({st.out_valid, st.out_last, frame_done, busy, overrun, st.out_row, st.out_col, st.out_data} !== '0)
      $display("FAIL reset state: valid=%b last=%b done=%b busy=%b ovr=%b row=%0d col=%0d data=%h, required all 0",
               st.out_valid, st.out_last, frame_done, busy, overrun, st.out_row, st.out_col, st.out_data);
    else pass_cnt++;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total_cnt++;
    if (busy !== 1'b0 || st.out_valid !== 1'b0)
      $display("FAIL reset release: busy=%b out_valid=%b, required 0 0", busy, st.out_valid);
    else pass_cnt++;
  endtask

  task automatic test_base_frame();
    int words;
    load_frame();
    send_frame("base", 4'd2, 4'd2);
    consume_frame("base", 7, 7, 1'b0, -1, words);
    total_cnt++;
    if (words !== 64) $display("FAIL base count: got %0d words, required 64", words);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    int words;
    load_frame();
    send_frame("backpressure", 4'd2, 4'd2);
    consume_frame("backpressure", 7, 7, 1'b1, -1, words);
    total_cnt++;
    if (words !== 64) $display("FAIL backpressure count: got %0d words, required 64", words);
    else pass_cnt++;
  endtask

  task automatic test_clamp();
    int words;
    load_frame();
    send_frame("clamp", 4'd0, 4'd12);
    consume_frame("clamp", 8, 0, 1'b0, -1, words);
    total_cnt++;
    if (words !== 9) $display("FAIL clamp count: got %0d words, required 9", words);
    else pass_cnt++;
  endtask

  task automatic test_overrun();
    int words;
    total_cnt++;
    if (overrun !== 1'b0) $display("FAIL overrun before: got %b, required 0", overrun);
    else pass_cnt++;
    load_frame();
    send_frame("overrun", 4'd2, 4'd2);
    consume_frame("overrun", 7, 7, 1'b0, 10, words);
    repeat (3) @(negedge clk);
    total_cnt++;
    if (overrun !== 1'b1 || busy !== 1'b0)
      $display("FAIL overrun sticky: overrun=%b busy=%b, required 1 0", overrun, busy);
    else pass_cnt++;
  endtask

  task automatic test_mid_reset();
    int  words;
    bit  done_seen;
    load_frame();
    st.out_ready = 1'b1;
    send_frame("midreset", 4'd2, 4'd2);
    repeat (20) begin
      @(posedge clk);
      @(negedge clk);
    end
    total_cnt++;
    if (st.out_row !== 4'd2 || st.out_col !== 4'd4 || st.out_valid !== 1'b1)
      $display("FAIL midreset word20: row=%0d col=%0d valid=%b, required 2 4 1",
               st.out_row, st.out_col, st.out_valid);
    else pass_cnt++;
    #2 rst = 1'b0;
    #1;
    total_cnt++;
    if ({st.out_valid, st.out_last, frame_done, busy, overrun, st.out_row, st.out_col, st.out_data} !== '0)
      $display("FAIL midreset clear: valid=%b last=%b done=%b busy=%b ovr=%b row=%0d col=%0d data=%h, required all 0",
               st.out_valid, st.out_last, frame_done, busy, overrun, st.out_row, st.out_col, st.out_data);
    else pass_cnt++;
    done_seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (frame_done !== 1'b0) done_seen = 1'b1;
    end
    rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (frame_done !== 1'b0) done_seen = 1'b1;
    end
    total_cnt++;
    if (done_seen) $display("FAIL midreset frame_done: got pulse, required none");
    else pass_cnt++;
    send_frame("restart", 4'd2, 4'd2);
    consume_frame("restart", 7, 7, 1'b0, -1, words);
    total_cnt++;
    if (words !== 64) $display("FAIL restart count: got %0d words, required 64", words);
    else pass_cnt++;
  endtask

  task automatic test_single_relu();
    int words;
    load_frame();
    tsv_in[0][0] = 42'h3FFFFFFFFFB;
`ifdef TSV_RELU_EN
    model[0][0] = 42'h0;
`else
    model[0][0] = 42'h3FFFFFFFFFB;
`endif
    send_frame("single", 4'd9, 4'd9);
    consume_frame("single", 0, 0, 1'b0, -1, words);
    total_cnt++;
    if (words !== 1) $display("FAIL single count: got %0d words, required 1", words);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_base_frame();
    test_backpressure();
    test_clamp();
    test_overrun();
    test_mid_reset();
    test_single_relu();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/tsv_collector.md
TSV_COLLECTOR -- requirements
Module: tsv_collector

Interface
REQ-001 Parameter GRID, default 9, PE array dimension per axis.
REQ-002 Parameter DW, default 42, result word width in bits.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 tsv_in  input  GRID x GRID x DW  Controller result array, indexed [row][col].
REQ-006 tsv_valid  input  1  one-cycle pulse; tsv_in holds a complete frame.
REQ-007 kernelsize_x  input  4  kernel rows of the frame, sampled with tsv_valid.
REQ-008 kernelsize_y  input  4  kernel columns of the frame, sampled with tsv_valid.
REQ-009 out_data  output  DW  current streamed result word.
REQ-010 out_row  output  4  row index of out_data.
REQ-011 out_col  output  4  column index of out_data.
REQ-012 out_valid  output  1  out_data/out_row/out_col are valid.
REQ-013 out_ready  input  1  downstream accepts the word when out_valid is high.
REQ-014 out_last  output  1  high with the final word of a frame.
REQ-015 frame_done  output  1  one-cycle pulse after the last word is accepted.
REQ-016 busy  output  1  high whenever the state is not IDLE.
REQ-017 overrun  output  1  sticky; a frame was dropped.

Function
REQ-018 The FSM SHALL have states IDLE, SEND and DONE.
REQ-019 In IDLE, tsv_valid=1 SHALL latch all of tsv_in into a shadow array, latch the clamped kernel sizes, set row=col=0 and enter SEND on the next edge.
REQ-020 Clamping: a kernel size of 0 SHALL be treated as 1 and a value above GRID as GRID.
REQ-021 Active region: rows 0..GRID-kx and columns 0..GRID-ky (kx, ky clamped), i.e. (GRID+1-kx) x (GRID+1-ky) words.
REQ-022 Latency: a tsv_valid sampled on edge N SHALL produce out_valid=1 with word (0,0) after edge N+1.
REQ-023 In SEND, out_valid SHALL be 1 and out_data SHALL equal shadow[row][col].
REQ-024 out_data/out_row/out_col SHALL remain stable while out_valid=1 and out_ready=0.
REQ-025 When out_valid and out_ready are both 1, the column SHALL advance.
REQ-026 At the last active column, the column SHALL wrap to 0 and the row SHALL increment.
REQ-027 out_last SHALL be 1 only when row and column are both at the last active index.
REQ-028 Acceptance of the out_last word SHALL move the FSM to DONE.
REQ-029 DONE SHALL last exactly one cycle, with frame_done=1 and out_valid=0, then return to IDLE.
REQ-030 A tsv_valid in SEND or DONE SHALL be ignored: the shadow array is unchanged and overrun is set.
REQ-031 Shadow contents SHALL change only on an accepted tsv_valid, so the Controller may overwrite tsv_in during SEND.
REQ-032 For kx=ky=GRID the frame SHALL be a single word with out_last=1.

Reset
REQ-033 Asserting rst low SHALL immediately force state IDLE and clear out_valid, out_last, frame_done, busy, overrun, out_row, out_col and out_data.
REQ-034 A reset in the middle of SEND SHALL abandon the frame; no frame_done is issued.
REQ-035 The shadow array needs no reset.
REQ-036 After rst is released, the first edge with tsv_valid=1 SHALL be accepted normally.

Configuration
REQ-037 With macro TSV_RELU_EN defined, out_data SHALL be 0 whenever the stored word is negative (bit DW-1 = 1, two's complement); otherwise the word passes unchanged.
REQ-038 Without TSV_RELU_EN, out_data SHALL always be the stored word unmodified.

Verification
REQ-039 Base frame: kernelsize 2/2, tsv_in[r][c]=r*16+c, out_ready=1 -> 64 words (0,0)..(7,7) on consecutive cycles, out_last on word (7,7) = 0x77, frame_done one cycle later.
REQ-040 Backpressure: out_ready toggles 1,0,0,1... -> no word lost or duplicated, outputs stable while stalled, order identical to REQ-039.
REQ-041 Clamping: kernelsize 0/12 -> 9x1 words, column always 0, rows 0..8.
REQ-042 Overrun: second tsv_valid with a changed tsv_in sent at word 10 -> stream still carries the first frame, overrun=1 until reset.
REQ-043 Reset: rst low at word 20 -> all outputs 0 asynchronously, no frame_done; a new frame after release starts at (0,0).
REQ-044 ReLU: with TSV_RELU_EN, tsv_in[0][0]=-5 -> out_data 0; without the macro -> 0x3FFFFFFFFFB.
